// File: rtl/fft_reorder.sv
// fft_reorder: ping-pong buffer turning bit-reversed FFT bins into natural order.
// Ports: clk/rst (sync, active-high); din_i/din_q/valid_in/sof_in/in_ready accept
// bit-reversed bins; dout_i/dout_q/dout_index/valid_out/eof_out/dout_ready deliver
// natural-order bins. Macro FFT_REORDER_OVF_FLAG_EN adds a sticky ovf_err output.
module fft_reorder #(
  parameter int SAMPLE_WORD_LENGTH = 8,
  parameter int FFT_POINTS = 16,
  localparam int ADDR_WIDTH = $clog2(FFT_POINTS)
) (
  input  logic clk,
  input  logic rst,
  input  logic signed [SAMPLE_WORD_LENGTH-1:0] din_i,
  input  logic signed [SAMPLE_WORD_LENGTH-1:0] din_q,
  input  logic valid_in,
  input  logic sof_in,
  output logic in_ready,
  output logic signed [SAMPLE_WORD_LENGTH-1:0] dout_i,
  output logic signed [SAMPLE_WORD_LENGTH-1:0] dout_q,
  output logic [ADDR_WIDTH-1:0] dout_index,
  output logic valid_out,
  output logic eof_out,
  input  logic dout_ready
`ifdef FFT_REORDER_OVF_FLAG_EN
  ,
  output logic ovf_err
`endif
);
  localparam int W = SAMPLE_WORD_LENGTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(FFT_POINTS - 1);
  logic [2*W-1:0] mem_q [2][FFT_POINTS];
  logic [1:0] full_q, full_d;
  logic wb_q, wb_d, rb_q, rb_d;
  logic [ADDR_WIDTH-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d, wr_addr;
  logic accept, xfer, wr_done, rd_done;
  logic [2*W-1:0] rd_data;
  function automatic logic [ADDR_WIDTH-1:0] bitrev(input logic [ADDR_WIDTH-1:0] a);
    for (int i = 0; i < ADDR_WIDTH; i++) bitrev[i] = a[ADDR_WIDTH-1-i];
  endfunction
  always_comb begin
    in_ready = !full_q[wb_q];
    accept = valid_in && in_ready;
    valid_out = full_q[rb_q];
    xfer = valid_out && dout_ready;
    wr_addr = sof_in ? '0 : bitrev(wcnt_q);
    wr_done = accept && !sof_in && wcnt_q == LAST;
    rd_done = xfer && rcnt_q == LAST;
    // wcnt wraps to 0 naturally on the last bin of a frame
    wcnt_d = !accept ? wcnt_q : sof_in ? ADDR_WIDTH'(1) : wcnt_q + 1'b1;
    rcnt_d = xfer ? rcnt_q + 1'b1 : rcnt_q;
    wb_d = wb_q ^ wr_done;
    rb_d = rb_q ^ rd_done;
    // a write completion needs !full[wb], a read completion needs full[rb]: never the same bank
    full_d = full_q;
    if (wr_done) full_d[wb_q] = 1'b1;
    if (rd_done) full_d[rb_q] = 1'b0;
    rd_data = mem_q[rb_q][rcnt_q];
    dout_i = valid_out ? rd_data[2*W-1:W] : '0;
    dout_q = valid_out ? rd_data[W-1:0] : '0;
    dout_index = valid_out ? rcnt_q : '0;
    eof_out = valid_out && rcnt_q == LAST;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= '0;
      wb_q <= 1'b0;
      rb_q <= 1'b0;
      wcnt_q <= '0;
      rcnt_q <= '0;
    end else begin
      full_q <= full_d;
      wb_q <= wb_d;
      rb_q <= rb_d;
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) mem_q[wb_q][wr_addr] <= {din_i, din_q};
  end
`ifdef FFT_REORDER_OVF_FLAG_EN
  logic ovf_q, ovf_d;
  always_comb begin
    ovf_d = ovf_q | (valid_in && !in_ready) | (accept && sof_in && wcnt_q != '0);
    ovf_err = ovf_q;
  end
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  end
`endif
endmodule

// File: tb/tb_fft_reorder.sv
// tb_fft_reorder: self-checking bench for fft_reorder (16 points, 8-bit samples).
module tb_fft_reorder;
  localparam int N = 16;
  logic clk = 1'b0, rst = 1'b1, valid_in = 1'b0, sof_in = 1'b0, dout_ready = 1'b0;
  logic signed [7:0] din_i = '0, din_q = '0;
  logic in_ready, valid_out, eof_out;
  logic signed [7:0] dout_i, dout_q;
  logic [3:0] dout_index;
`ifdef FFT_REORDER_OVF_FLAG_EN
  logic ovf_err;
  bit m_ovf = 0;
`endif
  fft_reorder #(.SAMPLE_WORD_LENGTH(8), .FFT_POINTS(N)) dut (
    .clk(clk), .rst(rst), .din_i(din_i), .din_q(din_q), .valid_in(valid_in),
    .sof_in(sof_in), .in_ready(in_ready), .dout_i(dout_i), .dout_q(dout_q),
    .dout_index(dout_index), .valid_out(valid_out), .eof_out(eof_out),
    .dout_ready(dout_ready)
`ifdef FFT_REORDER_OVF_FLAG_EN
    , .ovf_err(ovf_err)
`endif
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int brev(int k);
    int r = 0;
    for (int i = 0; i < 4; i++) if (k[i]) r |= 1 << (3 - i);
    return r;
  endfunction
  // Reference: a queue of completed natural-order frames; at most two can be held
  typedef logic [15:0] frame_t [N];
  frame_t fq[$];
  frame_t part;
  int wc = 0, rp = 0;
  bit can_w, can_r;
  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      wc = 0;
      rp = 0;
`ifdef FFT_REORDER_OVF_FLAG_EN
      m_ovf = 0;
`endif
    end else begin
      can_w = fq.size() < 2;
      can_r = fq.size() > 0;
      if (can_r && dout_ready) begin
        rp++;
        if (rp == N) begin
          void'(fq.pop_front());
          rp = 0;
        end
      end
`ifdef FFT_REORDER_OVF_FLAG_EN
      if (valid_in && (!can_w || (sof_in && wc != 0))) m_ovf = 1;
`endif
      if (valid_in && can_w) begin
        if (sof_in) wc = 0;
        part[brev(wc)] = {din_i, din_q};
        wc++;
        if (wc == N) begin
          fq.push_back(part);
          wc = 0;
        end
      end
    end
  end
  // Monitor: compare every cycle against the reference, check ordering and hold
  int nxt = 0, xfers = 0, cyc = 0, first_cyc = 0, last_cyc = 0;
  int ei, eq, ex, ee, ev;
  bit pv = 0;
  int pi, pq, px;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      nxt = 0;
      xfers = 0;
      pv = 0;
    end else begin
      ev = fq.size() > 0;
      ei = 0; eq = 0; ex = 0; ee = 0;
      if (ev) begin
        ei = $signed(fq[0][rp][15:8]);
        eq = $signed(fq[0][rp][7:0]);
        ex = rp;
        ee = rp == N - 1;
      end
      chk("in_ready", in_ready, fq.size() < 2);
      chk("valid_out", valid_out, ev);
      chk("dout_i", dout_i, ei);
      chk("dout_q", dout_q, eq);
      chk("dout_index", dout_index, ex);
      chk("eof_out", eof_out, ee);
`ifdef FFT_REORDER_OVF_FLAG_EN
      chk("ovf_err", ovf_err, m_ovf);
`endif
      if (pv) begin
        chk("hold_valid", valid_out, 1);
        chk("hold_i", dout_i, pi);
        chk("hold_q", dout_q, pq);
        chk("hold_index", dout_index, px);
      end
      pv = valid_out && !dout_ready;
      pi = dout_i; pq = dout_q; px = dout_index;
      if (valid_out && dout_ready) begin
        chk("order", dout_index, nxt);
        nxt = (nxt + 1) % N;
        if (xfers == 0) first_cyc = cyc;
        last_cyc = cyc;
        xfers++;
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1; valid_in = 0; sof_in = 0;
    tick();
    rst = 0;
  endtask
  task automatic send(int i, int q, bit s);
    valid_in = 1; din_i = 8'(i); din_q = 8'(q); sof_in = s;
    tick();
    valid_in = 0; sof_in = 0;
  endtask
  task automatic send_frame();
    for (int k = 0; k < N; k++) send($urandom, $urandom, k == 0);
  endtask
  typedef struct {
    int di, dq, ev, ei, eq, ex, ee;
  } vec_t;
  vec_t vt[N];
  bit found;
  initial begin
    for (int k = 0; k < N; k++) begin
      vt[k].di = brev(k); vt[k].dq = -brev(k);
      vt[k].ev = 1; vt[k].ei = k; vt[k].eq = -k; vt[k].ex = k; vt[k].ee = (k == N - 1);
    end
    do_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_valid", valid_out, 0);
    chk("rst_eof", eof_out, 0);
    chk("rst_dout_i", dout_i, 0);
    chk("rst_dout_q", dout_q, 0);
    chk("rst_index", dout_index, 0);
    // known frame: bins arrive bit-reversed, must leave in natural order
    dout_ready = 1;
    for (int k = 0; k < N; k++) send(vt[k].di, vt[k].dq, k == 0);
    for (int j = 0; j < N; j++) begin
      chk("tbl_valid", valid_out, vt[j].ev);
      chk("tbl_dout_i", dout_i, vt[j].ei);
      chk("tbl_dout_q", dout_q, vt[j].eq);
      chk("tbl_index", dout_index, vt[j].ex);
      chk("tbl_eof", eof_out, vt[j].ee);
      tick();
    end
    chk("tbl_valid_end", valid_out, 0);
    // back-to-back frames: no stall, no output gap
    do_reset();
    dout_ready = 1;
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < N; k++) begin
        chk("b2b_in_ready", in_ready, 1);
        send($urandom, $urandom, k == 0);
      end
    repeat (20) tick();
    chk("b2b_xfers", xfers, 64);
    chk("b2b_gapless", last_cyc - first_cyc, 63);
    // both banks full: 33rd sample dropped
    do_reset();
    dout_ready = 0;
    for (int s = 0; s < 2 * N; s++) send($urandom, $urandom, s % N == 0);
    chk("full_in_ready", in_ready, 0);
    send($urandom, $urandom, 0);
`ifdef FFT_REORDER_OVF_FLAG_EN
    chk("full_ovf", ovf_err, 1);
`endif
    dout_ready = 1;
    repeat (2 * N) tick();
    chk("full_xfers", xfers, 2 * N);
    chk("full_in_ready_after", in_ready, 1);
    chk("full_valid_after", valid_out, 0);
    // sof mid-frame discards the partial frame
    do_reset();
    dout_ready = 1;
    for (int s = 0; s < 5; s++) send($urandom, $urandom, s == 0);
    send_frame();
`ifdef FFT_REORDER_OVF_FLAG_EN
    chk("sof_ovf", ovf_err, 1);
`endif
    repeat (20) tick();
    chk("sof_xfers", xfers, N);
    // reset while index 7 is on the output
    do_reset();
    dout_ready = 1;
    send_frame();
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (valid_out && dout_index == 7) found = 1;
      else tick();
    end
    chk("wait_idx7", found, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_valid", valid_out, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_dout_i", dout_i, 0);
    chk("mid_rst_dout_q", dout_q, 0);
    chk("mid_rst_index", dout_index, 0);
    chk("mid_rst_eof", eof_out, 0);
`ifdef FFT_REORDER_OVF_FLAG_EN
    chk("mid_rst_ovf", ovf_err, 0);
`endif
    send_frame();
    repeat (20) tick();
    chk("post_rst_xfers", xfers, N);
    // consumer toggling ready every cycle
    do_reset();
    dout_ready = 1;
    send_frame();
    for (int c = 0; c < 40; c++) begin
      dout_ready = (c % 2 == 0);
      tick();
    end
    chk("toggle_xfers", xfers, N);
    // randomized traffic against the reference
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      valid_in = $urandom_range(0, 9) < 8;
      sof_in = $urandom_range(0, 19) == 0;
      din_i = 8'($urandom);
      din_q = 8'($urandom);
      dout_ready = $urandom_range(0, 9) < 7;
      tick();
    end
    valid_in = 0; sof_in = 0; dout_ready = 1;
    repeat (40) tick();
    chk("rand_drained", valid_out, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_reorder.md
FFT_REORDER -- requirements
Module: fft_reorder

Interface
REQ-001 SHALL have parameter SAMPLE_WORD_LENGTH, default 8, signed I/Q sample width matching the FFT core output.
REQ-002 SHALL have parameter FFT_POINTS, default 16, frame length: power of two, 4..64; ADDR_WIDTH = log2(FFT_POINTS), localparam.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port din_i, din_q  input  SAMPLE_WORD_LENGTH each  signed FFT bins, bit-reversed order.
REQ-006 SHALL have port valid_in  input  1  input sample present.
REQ-007 SHALL have port sof_in  input  1  first bin of frame, qualified by valid_in.
REQ-008 SHALL have port in_ready  output  1  write bank has space.
REQ-009 SHALL have port dout_i, dout_q  output  SAMPLE_WORD_LENGTH each  signed bins, natural order.
REQ-010 SHALL have port dout_index  output  ADDR_WIDTH  bin number of current output.
REQ-011 SHALL have port valid_out  output  1  output present.
REQ-012 SHALL have port eof_out  output  1  last bin of frame.
REQ-013 SHALL have port dout_ready  input  1  consumer accepts output.

Function
REQ-014 SHALL hold two banks (ping-pong), FFT_POINTS x 2*SAMPLE_WORD_LENGTH each, per-bank full flag, write-bank pointer wb, read-bank pointer rb, write counter wcnt, read counter rcnt.
REQ-015 SHALL drive in_ready = !full[wb].
REQ-016 SHALL, on accept (valid_in && in_ready), write {din_i,din_q} to bank wb at address bitrev(wcnt) and increment wcnt.
REQ-017 SHALL, on accept with sof_in=1, write to address 0 and set wcnt to 1, discarding any partial frame.
REQ-018 SHALL, on accept with wcnt = FFT_POINTS-1 (no sof_in), set full[wb], toggle wb, clear wcnt.
REQ-019 SHALL drive valid_out = full[rb]; dout_i/dout_q = bank rb entry rcnt; dout_index = rcnt; eof_out = valid_out && rcnt = FFT_POINTS-1.
REQ-020 SHALL force dout_i, dout_q, dout_index, eof_out to 0 while valid_out is 0.
REQ-021 SHALL, on transfer (valid_out && dout_ready), increment rcnt; at rcnt = FFT_POINTS-1 clear full[rb], toggle rb, clear rcnt.
REQ-022 SHALL assert valid_out in the cycle after the final accepted bin of a frame (latency 1 cycle from frame completion).
REQ-023 SHALL apply a write completion and a read completion in the same cycle independently, on different banks.
REQ-024 SHALL hold outputs stable while valid_out=1 and dout_ready=0.
REQ-025 SHALL drop valid_in while in_ready=0, leaving state unchanged.
REQ-026 SHALL sustain one bin per cycle in and out indefinitely when dout_ready=1.

Reset
REQ-027 SHALL, on rst=1 at a clk edge, clear wcnt, rcnt, wb, rb, both full flags; in-flight frames discarded.
REQ-028 SHALL give reset output values in_ready=1, valid_out=0, eof_out=0, dout_i=dout_q=dout_index=0.
REQ-029 SHALL NOT reset bank memory contents.

Configuration
REQ-030 SHALL, with macro FFT_REORDER_OVF_FLAG_EN defined, add port ovf_err  output  1: sticky, set by a dropped sample (valid_in && !in_ready) or by sof_in accepted with wcnt != 0, cleared only by rst.
REQ-031 SHALL, without FFT_REORDER_OVF_FLAG_EN, omit ovf_err port and logic; all other behaviour identical.

Verification (FFT_POINTS=16, SAMPLE_WORD_LENGTH=8)
REQ-032 SHALL cover: frame k=0..15 with din_i=bitrev(k), din_q=-bitrev(k), sof_in at k=0, dout_ready=1 -> valid_out 1 cycle after k=15; dout_i=0,1..15, dout_q=0,-1..-15, dout_index=0..15, eof_out at index 15 only.
REQ-033 SHALL cover: 4 back-to-back frames, dout_ready=1 -> in_ready never low, 64 consecutive outputs without gap, natural order each frame.
REQ-034 SHALL cover: dout_ready=0, 33 samples offered -> in_ready low after sample 32, sample 33 dropped, ovf_err=1 (macro); dout_ready=1 later -> 32 correct outputs, then in_ready=1.
REQ-035 SHALL cover: sof_in at sample 5 of frame -> partial frame never output, next 16 outputs from new frame, ovf_err=1 (macro).
REQ-036 SHALL cover: rst=1 mid-output at index 7 -> next cycle valid_out=0, in_ready=1, outputs 0, ovf_err=0; following frame reorders correctly.
REQ-037 SHALL cover: dout_ready toggling 1/0 each cycle -> each bin held until accepted, no loss or duplication, dout_index monotonic 0..15.
